// File: rtl/morse_playback_if.sv
// RAM read port between morse_playback (master) and the game RAM (slave).
interface morse_playback_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 10
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden;
  logic [DATA_W-1:0] ram_q;

  modport master (output ram_addr, output ram_rden, input  ram_q);
  modport slave  (input  ram_addr, input  ram_rden, output ram_q);
endinterface

// File: rtl/morse_playback.sv
// Walks stored 10-bit morse words out of the game RAM and blinks them on one LED,
// timing each symbol in units of an external one-cycle tick.
module morse_playback #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned DOT_UNITS  = 1,
  parameter int unsigned DASH_UNITS = 3,
  parameter int unsigned SYM_GAP    = 1,
  parameter int unsigned WORD_GAP   = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              tick,
  input  logic [ADDR_W:0]   length,
  morse_playback_if.master  ram,
  output logic              led,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_word
);
  localparam int unsigned LEN_W    = ADDR_W + 1;
  localparam int unsigned MAX_MARK = (DASH_UNITS > DOT_UNITS) ? DASH_UNITS : DOT_UNITS;
  localparam int unsigned MAX_GAP  = (WORD_GAP > SYM_GAP) ? WORD_GAP : SYM_GAP;
  localparam int unsigned MAX_U    = (MAX_GAP > MAX_MARK) ? MAX_GAP : MAX_MARK;
  localparam int unsigned CNT_W    = $clog2(MAX_U + 1);
  localparam int unsigned LAT_W    = 2;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_MARK, S_DECIDE, S_SGAP, S_WGAP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LAT_W-1:0]   lat_q, lat_d;

  logic [1:0]         sym_c;
  logic               sym_mark_c;
  logic [CNT_W-1:0]   sym_units_c;
  logic               last_word_c;
  logic               cnt_last_c;

  // Top symbol of the shift register decides both mark length and end of word.
  assign sym_c       = word_q[DATA_W-1 -: 2];
  assign sym_mark_c  = sym_c[1] ^ sym_c[0];
  assign sym_units_c = (sym_c == 2'b01) ? CNT_W'(DOT_UNITS) : CNT_W'(DASH_UNITS);
  assign last_word_c = (LEN_W'(idx_q) + LEN_W'(1)) >= len_q;
  assign cnt_last_c  = (cnt_q == CNT_W'(1));

  // State, datapath and outputs; outputs follow the next state so they line up with it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      lat_q        <= '0;
      led          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cur_word     <= '0;
      ram.ram_addr <= '0;
      ram.ram_rden <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      led          <= (state_d == S_MARK);
      busy         <= (state_d != S_IDLE);
      done         <= (state_d == S_DONE);
      ram.ram_rden <= (state_d == S_FETCH);
      if (state_d == S_FETCH) begin
        ram.ram_addr <= idx_d;
        cur_word     <= idx_d;
      end
    end
  end

  // Next-state logic; abort overrides everything at the end.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d   = (length > MAX_LEN) ? MAX_LEN : length;
          idx_d   = '0;
          state_d = (length == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        lat_d   = LAT_W'(RD_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          word_d  = ram.ram_q;
          state_d = S_LOAD;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_LOAD: begin
        if (sym_mark_c) begin
          cnt_d   = sym_units_c;
          state_d = S_MARK;
        end else begin
          state_d = S_DONE;
        end
      end
      S_MARK: begin
        if (tick) begin
          if (cnt_last_c) begin
            word_d  = word_q << 2;
            state_d = S_DECIDE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_DECIDE: begin
        if (sym_mark_c) begin
          if (SYM_GAP == 0) begin
            cnt_d   = sym_units_c;
            state_d = S_MARK;
          end else begin
            cnt_d   = CNT_W'(SYM_GAP);
            state_d = S_SGAP;
          end
        end else if (last_word_c) begin
          state_d = S_DONE;
        end else if (WORD_GAP == 0) begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else begin
          cnt_d   = CNT_W'(WORD_GAP);
          state_d = S_WGAP;
        end
      end
      S_SGAP: begin
        if (tick) begin
          if (cnt_last_c) begin
            cnt_d   = sym_units_c;
            state_d = S_MARK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_WGAP: begin
        if (tick) begin
          if (cnt_last_c) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end
endmodule
